// File: rtl/inv_square_recover.sv
`default_nettype none
// ============================================================================
// Module   : inv_square_recover
// Purpose  : Recovers x = 1/(y*y) from an IEEE-754 single y using one squaring
//            cycle followed by a restoring reciprocal divider (1 bit per clock).
// Revision : 1.0
// ============================================================================
module inv_square_recover #(
   parameter int QBITS = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] DataIn,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] DataOut,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy
);

   localparam int          CW      = $clog2(QBITS + 1);
   localparam logic [31:0] C_INF   = 32'h7F80_0000;
   localparam logic [31:0] C_ZERO  = 32'h0000_0000;
   localparam logic [31:0] C_QNAN  = 32'h7FC0_0000;
   localparam logic [23:0] C_ONE   = 24'h80_0000;
   localparam logic [25:0] C_TWO   = 26'h100_0000;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SQUARE = 3'd1,
      S_DIV    = 3'd2,
      S_PACK   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t            r_state;
   logic [7:0]        r_exp;
   logic [22:0]       r_frac;
   logic [23:0]       r_m2;
   logic [9:0]        r_e2;
   logic              r_one;
   logic [25:0]       r_rem;
   logic [QBITS-1:0]  r_q;
   logic [CW-1:0]     r_cnt;

   // Sign is dropped: the square is always positive.
   logic [30:0] w_mag;
   assign w_mag = 31'(DataIn);

   logic [23:0] w_m;
   logic [24:0] w_phi;
   logic        w_n;
   logic [23:0] w_m2;
   logic [9:0]  w_e2;
   assign w_m   = {1'b1, r_frac};
   assign w_phi = 25'(({24'd0, w_m} * {24'd0, w_m}) >> 23);
   assign w_n   = w_phi[24];
   assign w_m2  = w_n ? w_phi[24:1] : w_phi[23:0];
   assign w_e2  = (({2'b00, r_exp} - 10'd127) << 1) + {9'd0, w_n};

   logic        w_ge;
   logic [25:0] w_rem_nx;
   assign w_ge     = (r_rem >= {2'b00, r_m2});
   assign w_rem_nx = w_ge ? (r_rem - {2'b00, r_m2}) : r_rem;

   // Quotient of 2/M2 lies in (1,2) unless M2 is exactly 1.0.
   logic               w_adj;
   logic signed [9:0]  w_eb;
   logic [22:0]        w_mant;
   logic [31:0]        w_pack;
   assign w_adj  = ~r_one;
   assign w_eb   = $signed(10'd127 - r_e2 - {9'd0, w_adj});
   assign w_mant = r_one ? 23'd0 : 23'({r_q, 24'd0} >> QBITS);

   always_comb begin
      w_pack = {1'b0, w_eb[7:0], w_mant};
      if (w_eb >= 10'sd255)
         w_pack = C_INF;
      else if (w_eb <= 10'sd0)
         w_pack = C_ZERO;
   end

   assign in_ready = (r_state == S_IDLE);
   assign busy     = (r_state != S_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_exp     <= '0;
         r_frac    <= '0;
         r_m2      <= '0;
         r_e2      <= '0;
         r_one     <= 1'b0;
         r_rem     <= '0;
         r_q       <= '0;
         r_cnt     <= '0;
         DataOut   <= '0;
         out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  if (w_mag[30:23] == 8'd0) begin
                     DataOut   <= C_INF;
                     out_valid <= 1'b1;
                     r_state   <= S_DONE;
                  end else if (w_mag[30:23] == 8'hFF) begin
                     DataOut   <= (w_mag[22:0] == 23'd0) ? C_ZERO : C_QNAN;
                     out_valid <= 1'b1;
                     r_state   <= S_DONE;
                  end else begin
                     r_exp   <= w_mag[30:23];
                     r_frac  <= w_mag[22:0];
                     r_state <= S_SQUARE;
                  end
               end
            end
            S_SQUARE: begin
               r_m2    <= w_m2;
               r_e2    <= w_e2;
               r_one   <= (w_m2 == C_ONE);
               r_rem   <= C_TWO;
               r_q     <= '0;
               r_cnt   <= '0;
               r_state <= S_DIV;
            end
            S_DIV: begin
               r_q   <= {r_q[QBITS-2:0], w_ge};
               r_rem <= w_rem_nx << 1;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(QBITS - 1))
                  r_state <= S_PACK;
            end
            S_PACK: begin
               DataOut   <= w_pack;
               out_valid <= 1'b1;
               r_state   <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inv_square_recover.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_square_recover
// Purpose  : Self-checking bench for inv_square_recover against an integer
//            reference model of x = 1/(y*y).
// Revision : 1.0
// ============================================================================
module tb_inv_square_recover;

   localparam int QBITS    = 24;
   localparam int LAT_NORM = QBITS + 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] DataIn = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] DataOut;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   inv_square_recover #(.QBITS(QBITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .DataIn    (DataIn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .DataOut   (DataOut),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // x = 1/(y*y): square the significand, normalise, then floor(2/M2) by integer divide.
   function automatic logic [31:0] model(input logic [31:0] y);
      int          e, n, e2, adj, eb;
      longint      m, p, m2, q;
      logic [22:0] mant;
      e = int'(y[30:23]);
      if (e == 0)   return 32'h7F80_0000;
      if (e == 255) return (y[22:0] == 23'd0) ? 32'h0000_0000 : 32'h7FC0_0000;
      m = longint'({1'b1, y[22:0]});
      p = m * m;
      if (p >= (longint'(1) << 47)) begin m2 = p >> 24; n = 1; end
      else                          begin m2 = p >> 23; n = 0; end
      e2 = 2 * (e - 127) + n;
      if (m2 == (longint'(1) << 23)) begin
         mant = '0;
         adj  = 0;
      end else begin
         q    = (longint'(1) << 47) / m2;
         mant = q[22:0];
         adj  = 1;
      end
      eb = 127 - e2 - adj;
      if (eb >= 255) return 32'h7F80_0000;
      if (eb <= 0)   return 32'h0000_0000;
      return {1'b0, 8'(eb), mant};
   endfunction

   task automatic xact(input logic [31:0] y, output logic [31:0] res, output int lat);
      int w;
      @(negedge clk);
      w = 0;
      while (!in_ready && w < 200) begin @(negedge clk); w++; end
      DataIn   = y;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!out_valid && lat < 200);
      res = DataOut;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (DataOut !== 32'h0) begin n_fail++; $display("FAIL reset_dataout got=%h exp=%h", DataOut, 32'h0); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst = 1'b1;
   endtask

   task automatic test_directed();
      logic [31:0] ys [7] = '{32'h3F80_0000, 32'h4040_0000, 32'h4000_0000, 32'hC000_0000,
                              32'h3F00_0000, 32'h1F80_0000, 32'h5F80_0000};
      logic [31:0] xs [7] = '{32'h3F80_0000, 32'h3DE3_8E38, 32'h3E80_0000, 32'h3E80_0000,
                              32'h4080_0000, 32'h7F80_0000, 32'h0000_0000};
      logic [31:0] res;
      int          lat;
      for (int i = 0; i < 7; i++) begin
         xact(ys[i], res, lat);
         n_checks++; if (res !== xs[i]) begin n_fail++; $display("FAIL directed_result y=%h got=%h exp=%h", ys[i], res, xs[i]); end
         n_checks++; if (lat != LAT_NORM) begin n_fail++; $display("FAIL directed_latency y=%h got=%0d exp=%0d", ys[i], lat, LAT_NORM); end
      end
   endtask

   task automatic test_specials();
      logic [31:0] ys [4] = '{32'h0000_0000, 32'h0000_0001, 32'h7F80_0000, 32'h7FC0_0001};
      logic [31:0] xs [4] = '{32'h7F80_0000, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000};
      logic [31:0] res;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         xact(ys[i], res, lat);
         n_checks++; if (res !== xs[i]) begin n_fail++; $display("FAIL special_result y=%h got=%h exp=%h", ys[i], res, xs[i]); end
         n_checks++; if (lat != 1) begin n_fail++; $display("FAIL special_latency y=%h got=%0d exp=1", ys[i], lat); end
      end
   endtask

   task automatic test_random();
      logic [31:0] y, res, exp_x;
      logic [7:0]  e;
      int          lat, exp_lat;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            0:       e = 8'd0;
            1:       e = 8'hFF;
            2, 3:    e = 8'($urandom_range(1, 254));
            default: e = 8'($urandom_range(60, 194));
         endcase
         y       = {1'($urandom), e, 23'($urandom)};
         exp_x   = model(y);
         exp_lat = (e == 8'd0 || e == 8'hFF) ? 1 : LAT_NORM;
         xact(y, res, lat);
         n_checks++; if (res !== exp_x) begin n_fail++; $display("FAIL random_result y=%h got=%h exp=%h", y, res, exp_x); end
         n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL random_latency y=%h got=%0d exp=%0d", y, lat, exp_lat); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_x;
      int          w;
      exp_x = 32'h3DE3_8E38;
      @(negedge clk);
      DataIn   = 32'h4040_0000;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 200) begin @(negedge clk); w++; end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_timeout got=%b exp=1", out_valid); end
      for (int c = 0; c < 10; c++) begin
         if (c == 4) begin DataIn = 32'h3F80_0000; in_valid = 1'b1; end
         if (c == 5) in_valid = 1'b0;
         @(negedge clk);
         n_checks++; if (DataOut !== exp_x) begin n_fail++; $display("FAIL bp_dataout_stable cyc=%0d got=%h exp=%h", c, DataOut, exp_x); end
         n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_handshake_hold cyc=%0d got=%b%b exp=10", c, out_valid, in_ready); end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
      n_checks++; if (DataOut !== exp_x) begin n_fail++; $display("FAIL bp_dataout_held got=%h exp=%h", DataOut, exp_x); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_pulse_ignored cyc=%0d got=%b%b exp=00", c, out_valid, busy); end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res;
      int          lat;
      @(negedge clk);
      DataIn   = 32'h4040_0000;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      n_checks++; if (DataOut !== 32'h0) begin n_fail++; $display("FAIL midrst_dataout got=%h exp=0", DataOut); end
      @(negedge clk);
      rst = 1'b1;
      xact(32'h4000_0000, res, lat);
      n_checks++; if (res !== 32'h3E80_0000) begin n_fail++; $display("FAIL midrst_after_result got=%h exp=3e800000", res); end
      n_checks++; if (lat != LAT_NORM) begin n_fail++; $display("FAIL midrst_after_latency got=%0d exp=%0d", lat, LAT_NORM); end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_directed();
      test_specials();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
